btn_cmd_front: RTL and testbench

Button front end for the up/down counter datapath: synchronizes and debounces the four raw push-buttons (BTNU, BTND, BTNL, BTNR) and encodes each press into one command on a valid/ready interface. The command set is UP, DOWN, LOAD and CLEAR. The block sits between the board pins and the counter core, which consumes one command per handshake. Short debounce and repeat widths keep simulation fast, in the same way the counter's slow-clock width is shrunk on the bench.

---
 rtl/btn_cmd_pkg.sv | 48 ++++
 rtl/btn_cmd_front_debounce.sv | 60 ++++++
 rtl/btn_cmd_front.sv | 139 +++++++++++++
 tb/tb_btn_cmd_front.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/btn_cmd_pkg.sv
// -----------------------------------------------------------------------------
// btn_cmd_pkg
// Shared definitions for the push-button command front end:
//   - btn_cmd_t  : 2-bit command code carried on the cmd bus
//   - BTN_*      : bit index of each button in the {R,L,D,U} vectors
//   - prio_cmd   : picks the highest-priority pending button
// The button index of each button equals the code of the command it issues,
// so a command code also selects its own pending bit.
// -----------------------------------------------------------------------------
package btn_cmd_pkg;

   typedef enum logic [1:0] {
      CMD_UP    = 2'd0,
      CMD_DOWN  = 2'd1,
      CMD_LOAD  = 2'd2,
      CMD_CLEAR = 2'd3
   } btn_cmd_t;

   localparam int NUM_BTN = 4;
   localparam int BTN_U   = 0;
   localparam int BTN_D   = 1;
   localparam int BTN_L   = 2;
   localparam int BTN_R   = 3;

   // Service order, highest first: CLEAR > LOAD > UP > DOWN.
   // With nothing pending the result is CMD_DOWN; callers gate on |pend.
   function automatic btn_cmd_t prio_cmd(input logic [NUM_BTN-1:0] pend);
      btn_cmd_t pick;
      pick = CMD_DOWN;
      if (pend[BTN_R]) begin
         pick = CMD_CLEAR;
      end else if (pend[BTN_L]) begin
         pick = CMD_LOAD;
      end else if (pend[BTN_U]) begin
         pick = CMD_UP;
      end
      return pick;
   endfunction

   // One-hot pending mask for a command code.
   function automatic logic [NUM_BTN-1:0] cmd_mask(input btn_cmd_t c);
      logic [NUM_BTN-1:0] m;
      m = '0;
      m[c] = 1'b1;
      return m;
   endfunction

endpackage

// File: rtl/btn_cmd_front_debounce.sv
// -----------------------------------------------------------------------------
// btn_debounce
// One button's input path: two-flop synchronizer, debounce counter, stable
// level and a one-cycle press pulse on the rising edge of the stable level.
//
// Ports:
//   clk      in   clock
//   rst_n    in   synchronous active-low reset
//   btn_raw  in   raw asynchronous button pin
//   level    out  debounced stable level
//   press    out  high for one cycle after level rises
//
// A new level is accepted only after the synced input has differed from the
// stable level for 2^DEBOUNCE_W consecutive cycles; any cycle of agreement
// restarts the count, so shorter glitches never reach the stable level.
// -----------------------------------------------------------------------------
module btn_debounce #(
   parameter int DEBOUNCE_W = 20
) (
   input  logic clk,
   input  logic rst_n,
   input  logic btn_raw,
   output logic level,
   output logic press
);

   logic                  sync1;
   logic                  sync2;
   logic                  stable;
   logic                  stable_q;
   logic [DEBOUNCE_W-1:0] cnt;

   // Synchronizer, debounce counter and the delayed copy of the stable level
   // used for edge detection.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sync1    <= 1'b0;
         sync2    <= 1'b0;
         stable   <= 1'b0;
         stable_q <= 1'b0;
         cnt      <= '0;
      end else begin
         sync1    <= btn_raw;
         sync2    <= sync1;
         stable_q <= stable;
         if (sync2 == stable) begin
            cnt <= '0;
         end else if (cnt == '1) begin
            stable <= sync2;
            cnt    <= '0;
         end else begin
            cnt <= cnt + 1'b1;
         end
      end
   end

   assign level = stable;
   assign press = stable & ~stable_q;

endmodule

// File: rtl/btn_cmd_front.sv
// -----------------------------------------------------------------------------
// btn_cmd_front
// Button front end for the up/down counter: debounces BTNU/BTND/BTNL/BTNR and
// turns each press into one command on a valid/ready interface.
//
// Ports:
//   clk        in   clock
//   rst_n      in   synchronous active-low reset
//   BTNU/D/L/R in   raw buttons (up, down, load, clear)
//   load       in   8-bit switch value sent with CMD_LOAD
//   cmd_valid  out  command available
//   cmd_ready  in   consumer accepts on an edge where cmd_valid is high
//   cmd        out  command code (btn_cmd_pkg::btn_cmd_t)
//   cmd_data   out  load value for CMD_LOAD, 0 otherwise
//   btn_level  out  debounced levels {R,L,D,U}
//   overrun    out  sticky: a press arrived while its button was still pending
//
// Optional feature: define BTN_AUTOREPEAT_EN to make held UP/DOWN buttons
// re-issue their command every 2^REPEAT_W cycles. Without it REPEAT_W has no
// effect and no repeat logic exists.
// -----------------------------------------------------------------------------
module btn_cmd_front
   import btn_cmd_pkg::*;
#(
   parameter int DEBOUNCE_W = 20,
   parameter int REPEAT_W   = 24
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       BTNU,
   input  logic       BTND,
   input  logic       BTNL,
   input  logic       BTNR,
   input  logic [7:0] load,
   output logic       cmd_valid,
   input  logic       cmd_ready,
   output logic [1:0] cmd,
   output logic [7:0] cmd_data,
   output logic [3:0] btn_level,
   output logic       overrun
);

   if (DEBOUNCE_W < 1 || REPEAT_W < 1) begin : g_param_check
      $error("btn_cmd_front: DEBOUNCE_W and REPEAT_W must be at least 1");
   end

   logic [NUM_BTN-1:0] btn_raw;
   logic [NUM_BTN-1:0] level;
   logic [NUM_BTN-1:0] press_evt;
   logic [NUM_BTN-1:0] rep_evt;
   logic [NUM_BTN-1:0] pending;
   logic [NUM_BTN-1:0] served;
   btn_cmd_t           grant_cmd;
   btn_cmd_t           cmd_q;
   logic               load_en;
   logic               serve;

   assign btn_raw = {BTNR, BTNL, BTND, BTNU};

   for (genvar i = 0; i < NUM_BTN; i++) begin : g_btn
      btn_debounce #(
         .DEBOUNCE_W (DEBOUNCE_W)
      ) u_debounce (
         .clk     (clk),
         .rst_n   (rst_n),
         .btn_raw (btn_raw[i]),
         .level   (level[i]),
         .press   (press_evt[i])
      );
   end

`ifdef BTN_AUTOREPEAT_EN
   // Auto-repeat for UP and DOWN only. The counter is zero on the press cycle
   // and fires when it reaches all-ones, i.e. every 2^REPEAT_W cycles after
   // the press while the stable level stays high; release clears it.
   for (genvar r = BTN_U; r <= BTN_D; r++) begin : g_repeat
      logic [REPEAT_W-1:0] rep_cnt;

      always_ff @(posedge clk) begin
         if (!rst_n || !level[r] || press_evt[r]) begin
            rep_cnt <= '0;
         end else begin
            rep_cnt <= rep_cnt + 1'b1;
         end
      end

      assign rep_evt[r] = level[r] & ~press_evt[r] & (rep_cnt == '1);
   end
   assign rep_evt[BTN_R:BTN_L] = '0;
`else
   assign rep_evt = '0;
`endif

   // Arbiter: the output register refills when empty or being accepted, and
   // takes the highest-priority pending button.
   always_comb begin
      load_en   = !cmd_valid || cmd_ready;
      grant_cmd = prio_cmd(pending);
      serve     = load_en && (pending != '0);
      served    = '0;
      if (serve) begin
         served = cmd_mask(grant_cmd);
      end
   end

   // Pending bits: a press on a button being served on the same edge keeps
   // the bit set and is not an overrun. Repeat events never raise overrun.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         pending <= '0;
         overrun <= 1'b0;
      end else begin
         pending <= (pending & ~served) | press_evt | rep_evt;
         if ((press_evt & pending & ~served) != '0) begin
            overrun <= 1'b1;
         end
      end
   end

   // Output register: holds cmd/cmd_data/cmd_valid until accepted. LOAD
   // captures the switches at serve time, not at press time.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cmd_valid <= 1'b0;
         cmd_q     <= CMD_UP;
         cmd_data  <= 8'h00;
      end else if (load_en) begin
         cmd_valid <= serve;
         if (serve) begin
            cmd_q    <= grant_cmd;
            cmd_data <= (grant_cmd == CMD_LOAD) ? load : 8'h00;
         end
      end
   end

   assign cmd       = cmd_q;
   assign btn_level = level;

endmodule

// File: tb/tb_btn_cmd_front.sv
// -----------------------------------------------------------------------------
// tb_btn_cmd_front
// Self-checking bench for btn_cmd_front with DEBOUNCE_W=1, REPEAT_W=2.
// Expected commands (code, data, cycle seen relative to stimulus start) are
// queued as stimulus is applied; a monitor queues every handshake the DUT
// performs, and each test task compares the two queues.
// -----------------------------------------------------------------------------
module tb_btn_cmd_front;
   import btn_cmd_pkg::*;

   typedef struct packed {
      logic [1:0]  c;
      logic [7:0]  d;
      logic [15:0] at;
   } rec_t;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       BTNU = 1'b0;
   logic       BTND = 1'b0;
   logic       BTNL = 1'b0;
   logic       BTNR = 1'b0;
   logic [7:0] load = 8'h00;
   logic       cmd_ready = 1'b0;
   logic       cmd_valid;
   logic [1:0] cmd;
   logic [7:0] cmd_data;
   logic [3:0] btn_level;
   logic       overrun;

   rec_t obs_q[$];
   rec_t exp_q[$];
   int   checks = 0;
   int   failures = 0;
   int   cyc = 0;
   int   t0 = 0;

   btn_cmd_front #(
      .DEBOUNCE_W (1),
      .REPEAT_W   (2)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .BTNU      (BTNU),
      .BTND      (BTND),
      .BTNL      (BTNL),
      .BTNR      (BTNR),
      .load      (load),
      .cmd_valid (cmd_valid),
      .cmd_ready (cmd_ready),
      .cmd       (cmd),
      .cmd_data  (cmd_data),
      .btn_level (btn_level),
      .overrun   (overrun)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Handshake monitor, sampled between edges after inputs have settled.
   always @(negedge clk) begin
      #2;
      if (rst_n && cmd_valid && cmd_ready) begin
         obs_q.push_back(rec_t'{cmd, cmd_data, 16'(cyc - t0)});
      end
   end

   task automatic start_test();
      @(negedge clk);
      obs_q.delete();
      exp_q.delete();
      t0 = cyc;
   endtask

   task automatic test_reset();
      BTNU = 1'b1; BTND = 1'b1; BTNL = 1'b1; BTNR = 1'b1;
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      checks++; if (cmd_valid !== 1'b0) begin failures++; $display("[TB] FAIL reset_valid got=%b want=0", cmd_valid); end
      checks++; if (cmd !== 2'b00) begin failures++; $display("[TB] FAIL reset_cmd got=%0d want=0", cmd); end
      checks++; if (cmd_data !== 8'h00) begin failures++; $display("[TB] FAIL reset_data got=%h want=00", cmd_data); end
      checks++; if (btn_level !== 4'h0) begin failures++; $display("[TB] FAIL reset_level got=%b want=0000", btn_level); end
      checks++; if (overrun !== 1'b0) begin failures++; $display("[TB] FAIL reset_overrun got=%b want=0", overrun); end
      BTNU = 1'b0; BTND = 1'b0; BTNL = 1'b0; BTNR = 1'b0;
      rst_n = 1'b1;
      repeat (4) @(negedge clk);
   endtask

   task automatic test_single_up();
      int nvalid;
      nvalid = 0;
      start_test();
      cmd_ready = 1'b1;
      BTNU = 1'b1;
      exp_q.push_back(rec_t'{CMD_UP, 8'h00, 16'd6});
      for (int k = 1; k <= 24; k++) begin
         @(negedge clk);
         if (k == 3 || k == 4) begin
            checks++;
            if (btn_level[0] !== (k >= 4)) begin
               failures++;
               $display("[TB] FAIL up_level_edge%0d got=%b want=%b", k, btn_level[0], (k >= 4));
            end
         end
         if (cmd_valid) nvalid++;
         if (k == 10) BTNU = 1'b0;
      end
      checks++; if (nvalid != 1) begin failures++; $display("[TB] FAIL up_valid_cycles got=%0d want=1", nvalid); end
      checks++; if (obs_q.size() != exp_q.size()) begin failures++; $display("[TB] FAIL up_count got=%0d want=%0d", obs_q.size(), exp_q.size()); end
      foreach (exp_q[i]) if (i < obs_q.size()) begin
         checks++;
         if (obs_q[i] !== exp_q[i]) begin
            failures++;
            $display("[TB] FAIL up_cmd[%0d] got cmd=%0d data=%h at=%0d want cmd=%0d data=%h at=%0d", i, obs_q[i].c, obs_q[i].d, obs_q[i].at, exp_q[i].c, exp_q[i].d, exp_q[i].at);
         end
      end
   endtask

   task automatic test_load_hold();
      start_test();
      cmd_ready = 1'b0;
      load = 8'hAA;
      BTNL = 1'b1;
      exp_q.push_back(rec_t'{CMD_LOAD, 8'h55, 16'd11});
      for (int k = 1; k <= 20; k++) begin
         @(negedge clk);
         if (k >= 6 && k <= 11) begin
            checks++;
            if ({cmd_valid, cmd, cmd_data} !== {1'b1, 2'd2, 8'h55}) begin
               failures++;
               $display("[TB] FAIL load_hold_k%0d got valid=%b cmd=%0d data=%h want valid=1 cmd=2 data=55", k, cmd_valid, cmd, cmd_data);
            end
         end
         if (k == 12) begin
            checks++;
            if (cmd_valid !== 1'b0) begin failures++; $display("[TB] FAIL load_drop got=%b want=0", cmd_valid); end
         end
         if (k == 3) load = 8'h55;
         if (k == 6) BTNL = 1'b0;
         if (k == 8) load = 8'h33;
         if (k == 11) cmd_ready = 1'b1;
      end
      checks++; if (obs_q.size() != exp_q.size()) begin failures++; $display("[TB] FAIL load_count got=%0d want=%0d", obs_q.size(), exp_q.size()); end
      foreach (exp_q[i]) if (i < obs_q.size()) begin
         checks++;
         if (obs_q[i] !== exp_q[i]) begin
            failures++;
            $display("[TB] FAIL load_cmd[%0d] got cmd=%0d data=%h at=%0d want cmd=%0d data=%h at=%0d", i, obs_q[i].c, obs_q[i].d, obs_q[i].at, exp_q[i].c, exp_q[i].d, exp_q[i].at);
         end
      end
   endtask

   task automatic test_back_to_back();
      start_test();
      cmd_ready = 1'b1;
      BTNU = 1'b1; BTND = 1'b1; BTNR = 1'b1;
      exp_q.push_back(rec_t'{CMD_CLEAR, 8'h00, 16'd6});
      exp_q.push_back(rec_t'{CMD_UP,    8'h00, 16'd7});
      exp_q.push_back(rec_t'{CMD_DOWN,  8'h00, 16'd8});
      for (int k = 1; k <= 20; k++) begin
         @(negedge clk);
         if (k == 6) begin BTNU = 1'b0; BTND = 1'b0; BTNR = 1'b0; end
      end
      checks++; if (overrun !== 1'b0) begin failures++; $display("[TB] FAIL b2b_overrun got=%b want=0", overrun); end
      checks++; if (obs_q.size() != exp_q.size()) begin failures++; $display("[TB] FAIL b2b_count got=%0d want=%0d", obs_q.size(), exp_q.size()); end
      foreach (exp_q[i]) if (i < obs_q.size()) begin
         checks++;
         if (obs_q[i] !== exp_q[i]) begin
            failures++;
            $display("[TB] FAIL b2b_cmd[%0d] got cmd=%0d data=%h at=%0d want cmd=%0d data=%h at=%0d", i, obs_q[i].c, obs_q[i].d, obs_q[i].at, exp_q[i].c, exp_q[i].d, exp_q[i].at);
         end
      end
   endtask

   task automatic test_glitch_overrun();
      logic level_seen;
      level_seen = 1'b0;
      start_test();
      cmd_ready = 1'b1;
      BTNU = 1'b1;
      for (int k = 1; k <= 10; k++) begin
         @(negedge clk);
         if (k == 1) BTNU = 1'b0;
         if (btn_level !== 4'h0) level_seen = 1'b1;
      end
      checks++; if (level_seen !== 1'b0) begin failures++; $display("[TB] FAIL glitch_level got=1 want=0"); end
      checks++; if (obs_q.size() != 0) begin failures++; $display("[TB] FAIL glitch_cmds got=%0d want=0", obs_q.size()); end

      // Three DOWN presses with ready low: the first fills the output
      // register, the second waits pending, the third finds it pending.
      start_test();
      cmd_ready = 1'b0;
      BTND = 1'b1;
      exp_q.push_back(rec_t'{CMD_DOWN, 8'h00, 16'd26});
      exp_q.push_back(rec_t'{CMD_DOWN, 8'h00, 16'd27});
      for (int k = 1; k <= 34; k++) begin
         @(negedge clk);
         if (k == 16) begin
            checks++;
            if (overrun !== 1'b0) begin failures++; $display("[TB] FAIL overrun_early got=%b want=0", overrun); end
         end
         if (k == 24) begin
            checks++;
            if (overrun !== 1'b1) begin failures++; $display("[TB] FAIL overrun_set got=%b want=1", overrun); end
            checks++;
            if ({cmd_valid, cmd} !== {1'b1, 2'd1}) begin failures++; $display("[TB] FAIL overrun_held got valid=%b cmd=%0d want valid=1 cmd=1", cmd_valid, cmd); end
         end
         BTND = (k < 20) && ((k / 4) % 2 == 0);
         if (k == 26) cmd_ready = 1'b1;
      end
      checks++; if (overrun !== 1'b1) begin failures++; $display("[TB] FAIL overrun_sticky got=%b want=1", overrun); end
      checks++; if (obs_q.size() != exp_q.size()) begin failures++; $display("[TB] FAIL overrun_count got=%0d want=%0d", obs_q.size(), exp_q.size()); end
      foreach (exp_q[i]) if (i < obs_q.size()) begin
         checks++;
         if (obs_q[i] !== exp_q[i]) begin
            failures++;
            $display("[TB] FAIL overrun_cmd[%0d] got cmd=%0d data=%h at=%0d want cmd=%0d data=%h at=%0d", i, obs_q[i].c, obs_q[i].d, obs_q[i].at, exp_q[i].c, exp_q[i].d, exp_q[i].at);
         end
      end
   endtask

   task automatic test_autorepeat();
      start_test();
      cmd_ready = 1'b1;
      BTNU = 1'b1;
`ifdef BTN_AUTOREPEAT_EN
      for (int i = 0; i < 5; i++) exp_q.push_back(rec_t'{CMD_UP, 8'h00, 16'(6 + 4 * i)});
`else
      exp_q.push_back(rec_t'{CMD_UP, 8'h00, 16'd6});
`endif
      for (int k = 1; k <= 36; k++) begin
         @(negedge clk);
         if (k == 20) BTNU = 1'b0;
      end
      checks++; if (obs_q.size() != exp_q.size()) begin failures++; $display("[TB] FAIL repeat_count got=%0d want=%0d", obs_q.size(), exp_q.size()); end
      foreach (exp_q[i]) if (i < obs_q.size()) begin
         checks++;
         if (obs_q[i] !== exp_q[i]) begin
            failures++;
            $display("[TB] FAIL repeat_cmd[%0d] got cmd=%0d data=%h at=%0d want cmd=%0d data=%h at=%0d", i, obs_q[i].c, obs_q[i].d, obs_q[i].at, exp_q[i].c, exp_q[i].d, exp_q[i].at);
         end
      end
   endtask

   task automatic test_reset_mid();
      start_test();
      cmd_ready = 1'b0;
      load = 8'h77;
      BTNL = 1'b1;
      for (int k = 1; k <= 20; k++) begin
         @(negedge clk);
         if (k == 7) begin
            checks++;
            if (cmd_valid !== 1'b1) begin failures++; $display("[TB] FAIL midrst_before got=%b want=1", cmd_valid); end
            rst_n = 1'b0;
         end
         if (k == 8) begin
            checks++;
            if ({cmd_valid, cmd, cmd_data, btn_level, overrun} !== 16'h0000) begin
               failures++;
               $display("[TB] FAIL midrst_outputs got valid=%b cmd=%0d data=%h level=%b ovr=%b want all 0", cmd_valid, cmd, cmd_data, btn_level, overrun);
            end
            BTNL = 1'b0;
            rst_n = 1'b1;
            cmd_ready = 1'b1;
         end
      end
      checks++; if (obs_q.size() != 0) begin failures++; $display("[TB] FAIL midrst_cmds got=%0d want=0", obs_q.size()); end
   endtask

   initial begin
      test_reset();
      test_single_up();
      test_load_hold();
      test_back_to_back();
      test_glitch_overrun();
      test_autorepeat();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
